// File: rtl/jailbreak_hs_pkg.sv
// Shared definitions for the high-score RAM bridge: request record, window
// constants and the responder state encoding.
package jailbreak_hs_pkg;

    // Save-image windows inside core RAM
    localparam logic [11:0] HS1_MAP_DEFAULT = 12'h620;
    localparam logic [6:0]  HS1_LEN_DEFAULT = 7'h50;
    localparam logic [11:0] HS2_MAP_DEFAULT = 12'h57E;
    localparam logic [6:0]  HS2_LEN_DEFAULT = 7'h03;

    // Data returned for reads outside both windows
    localparam logic [7:0]  OOR_READ_DATA   = 8'hFF;

    // One request as it crosses from the clk_74a side
    typedef struct packed {
        logic [6:0] address;
        logic [7:0] data;
        logic       is_write;
    } mem_access_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_OOR    = 2'd3
    } state_t;

endpackage

// File: rtl/hs_ram_responder_if.sv
// Request/response handshake between the CDC FIFO head and the responder.
interface hs_ram_responder_if;
    logic       req_valid;
    logic [6:0] req_address;
    logic [7:0] req_data;
    logic       req_is_write;
    logic       req_ack;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    // FIFO / return-buffer side
    modport master (
        output req_valid, req_address, req_data, req_is_write,
        input  req_ack, rsp_valid, rsp_data
    );

    // Responder side
    modport slave (
        input  req_valid, req_address, req_data, req_is_write,
        output req_ack, rsp_valid, rsp_data
    );
endinterface

// File: rtl/hs_addr_remap.sv
// Maps a save-image byte offset onto core RAM through two windows.
module hs_addr_remap
    import jailbreak_hs_pkg::*;
#(
    parameter logic [11:0] HS1_MAP = HS1_MAP_DEFAULT,
    parameter logic [6:0]  HS1_LEN = HS1_LEN_DEFAULT,
    parameter logic [11:0] HS2_MAP = HS2_MAP_DEFAULT,
    parameter logic [6:0]  HS2_LEN = HS2_LEN_DEFAULT
) (
    input  logic [6:0]  address,
    output logic [11:0] mapped_address,
    output logic        in_range
);

    // Window bounds compared in 8 bits so LEN1+LEN2 cannot wrap
    logic [7:0]  addr_ext;
    logic [7:0]  win1_end;
    logic [7:0]  win2_end;
    logic [11:0] addr_12;
    logic [11:0] len1_12;

    assign addr_ext = {1'b0, address};
    assign win1_end = {1'b0, HS1_LEN};
    assign win2_end = {1'b0, HS1_LEN} + {1'b0, HS2_LEN};
    assign addr_12  = {5'b0, address};
    assign len1_12  = {5'b0, HS1_LEN};

    // Window select and offset add
    always_comb begin
        mapped_address = 12'h000;
        in_range       = 1'b0;
        if (addr_ext < win1_end) begin
            mapped_address = HS1_MAP + addr_12;
            in_range       = 1'b1;
        end else if (addr_ext < win2_end) begin
            mapped_address = HS2_MAP + (addr_12 - len1_12);
            in_range       = 1'b1;
        end
    end

endmodule

// File: rtl/hs_ram_responder.sv
// Services save-image requests against the shared core RAM port.
// A request is acked in IDLE, the port is claimed for SETUP plus
// READ_LATENCY (or one write) ACCESS cycles, and read data is returned
// with a one-cycle rsp_valid strobe as the block re-enters IDLE.
module hs_ram_responder
    import jailbreak_hs_pkg::*;
#(
    parameter logic [11:0] HS1_MAP      = HS1_MAP_DEFAULT,
    parameter logic [6:0]  HS1_LEN      = HS1_LEN_DEFAULT,
    parameter logic [11:0] HS2_MAP      = HS2_MAP_DEFAULT,
    parameter logic [6:0]  HS2_LEN      = HS2_LEN_DEFAULT,
    parameter int          READ_LATENCY = 1
) (
    input  logic                      jb_core_clk,
    input  logic                      reset_n,
    hs_ram_responder_if.slave         req_if,
    input  logic                      cpu_ram_busy,
    output logic [11:0]               hs_address,
    output logic                      hs_access,
    output logic                      hs_write_enable,
    output logic [7:0]                hs_data_in,
    input  logic [7:0]                hs_data_out,
    output logic [7:0]                oor_count
);

    // Latency outside 1..3 is clamped so the counter width stays fixed
    localparam int         LAT      = (READ_LATENCY < 1) ? 1 :
                                      (READ_LATENCY > 3) ? 3 : READ_LATENCY;
    localparam logic [1:0] LAT_LAST = 2'(LAT - 1);

    state_t      state_reg, state_next;
    mem_access_t req_in;
    logic        is_write_reg, is_write_next;
    logic [1:0]  lat_cnt_reg, lat_cnt_next;
    logic [11:0] hs_address_reg, hs_address_next;
    logic [7:0]  hs_data_in_reg, hs_data_in_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [7:0]  rsp_data_reg, rsp_data_next;
    logic [7:0]  oor_count_reg, oor_count_next;
    logic        req_ack_comb;
    logic [11:0] mapped_address;
    logic        in_range;

    assign req_in = '{address:  req_if.req_address,
                      data:     req_if.req_data,
                      is_write: req_if.req_is_write};

    hs_addr_remap #(
        .HS1_MAP (HS1_MAP),
        .HS1_LEN (HS1_LEN),
        .HS2_MAP (HS2_MAP),
        .HS2_LEN (HS2_LEN)
    ) u_remap (
        .address        (req_in.address),
        .mapped_address (mapped_address),
        .in_range       (in_range)
    );

    // Next-state, port control and register updates
    always_comb begin
        state_next      = state_reg;
        is_write_next   = is_write_reg;
        lat_cnt_next    = lat_cnt_reg;
        hs_address_next = hs_address_reg;
        hs_data_in_next = hs_data_in_reg;
        rsp_valid_next  = 1'b0;
        rsp_data_next   = rsp_data_reg;
        oor_count_next  = oor_count_reg;
        req_ack_comb    = 1'b0;
        hs_access       = 1'b0;
        hs_write_enable = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    if (!in_range) begin
                        // Out-of-range requests never touch RAM, so busy is irrelevant
                        req_ack_comb = 1'b1;
                        state_next   = ST_OOR;
                        if (!req_in.is_write) begin
                            rsp_valid_next = 1'b1;
                            rsp_data_next  = OOR_READ_DATA;
                        end
                        if (oor_count_reg != 8'hFF) begin
                            oor_count_next = oor_count_reg + 8'd1;
                        end
                    end else if (!cpu_ram_busy) begin
                        req_ack_comb    = 1'b1;
                        is_write_next   = req_in.is_write;
                        hs_address_next = mapped_address;
                        if (req_in.is_write) begin
                            hs_data_in_next = req_in.data;
                        end
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                hs_access    = 1'b1;
                lat_cnt_next = is_write_reg ? 2'd0 : LAT_LAST;
                state_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                hs_access = 1'b1;
                if (is_write_reg) begin
                    hs_write_enable = 1'b1;
                    state_next      = ST_IDLE;
                end else if (lat_cnt_reg == 2'd0) begin
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = hs_data_out;
                    state_next     = ST_IDLE;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 2'd1;
                end
            end
            ST_OOR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge jb_core_clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            is_write_reg   <= 1'b0;
            lat_cnt_reg    <= 2'd0;
            hs_address_reg <= 12'h000;
            hs_data_in_reg <= 8'h00;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= 8'h00;
            oor_count_reg  <= 8'h00;
        end else begin
            state_reg      <= state_next;
            is_write_reg   <= is_write_next;
            lat_cnt_reg    <= lat_cnt_next;
            hs_address_reg <= hs_address_next;
            hs_data_in_reg <= hs_data_in_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            oor_count_reg  <= oor_count_next;
        end
    end

    // Never pop the FIFO while reset is held
    assign req_if.req_ack   = req_ack_comb & reset_n;
    assign req_if.rsp_valid = rsp_valid_reg;
    assign req_if.rsp_data  = rsp_data_reg;
    assign hs_address       = hs_address_reg;
    assign hs_data_in       = hs_data_in_reg;
    assign oor_count        = oor_count_reg;

endmodule

// File: tb/tb_hs_ram_responder.sv
// Directed bench for hs_ram_responder with a small behavioural core RAM.
module tb_hs_ram_responder;

    logic        jb_core_clk = 1'b0;
    logic        reset_n     = 1'b0;
    logic        cpu_ram_busy = 1'b0;
    logic [11:0] hs_address;
    logic        hs_access;
    logic        hs_write_enable;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic [7:0]  oor_count;
    logic [7:0]  ram [0:4095];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 jb_core_clk = ~jb_core_clk;

    hs_ram_responder_if bus ();

    hs_ram_responder dut (
        .jb_core_clk     (jb_core_clk),
        .reset_n         (reset_n),
        .req_if          (bus),
        .cpu_ram_busy    (cpu_ram_busy),
        .hs_address      (hs_address),
        .hs_access       (hs_access),
        .hs_write_enable (hs_write_enable),
        .hs_data_in      (hs_data_in),
        .hs_data_out     (hs_data_out),
        .oor_count       (oor_count)
    );

    // Core RAM: asynchronous read, write on the clock; known contents reloaded in reset
    assign hs_data_out = ram[hs_address];
    always @(posedge jb_core_clk) begin
        if (!reset_n) begin
            ram[12'h620] <= 8'h11;
            ram[12'h66F] <= 8'h22;
            ram[12'h57F] <= 8'h3C;
            ram[12'h630] <= 8'h77;
        end else if (hs_access && hs_write_enable) begin
            ram[hs_address] <= hs_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point)
    task automatic step();
        @(posedge jb_core_clk);
        #1;
    endtask

    // Sample point in the middle of the current cycle
    task automatic samp();
        @(negedge jb_core_clk);
    endtask

    // One in-range request, checked cycle by cycle from N to N+3
    task automatic run_req(input string tag, input logic [6:0] a, input logic [7:0] d,
                           input logic w, input logic [11:0] exp_map, input logic [7:0] exp_rd);
        step();
        bus.req_valid = 1'b1; bus.req_address = a; bus.req_data = d; bus.req_is_write = w;
        samp();
        chk({tag, "_ack_N"}, 32'(bus.req_ack), 1);
        chk({tag, "_acc_N"}, 32'(hs_access), 0);
        step();
        bus.req_valid = 1'b0;
        samp();
        chk({tag, "_ack_N1"}, 32'(bus.req_ack), 0);
        chk({tag, "_acc_N1"}, 32'(hs_access), 1);
        chk({tag, "_addr_N1"}, 32'(hs_address), 32'(exp_map));
        chk({tag, "_we_N1"}, 32'(hs_write_enable), 0);
        step();
        samp();
        chk({tag, "_acc_N2"}, 32'(hs_access), 1);
        chk({tag, "_we_N2"}, 32'(hs_write_enable), 32'(w));
        if (w) chk({tag, "_wdata_N2"}, 32'(hs_data_in), 32'(d));
        step();
        samp();
        chk({tag, "_acc_N3"}, 32'(hs_access), 0);
        chk({tag, "_we_N3"}, 32'(hs_write_enable), 0);
        chk({tag, "_rspv_N3"}, 32'(bus.rsp_valid), 32'(!w));
        chk({tag, "_addr_hold_N3"}, 32'(hs_address), 32'(exp_map));
        if (!w) chk({tag, "_rdata_N3"}, 32'(bus.rsp_data), 32'(exp_rd));
        $display("req %s addr=0x%02h wr=%0d map=0x%03h rsp_valid=%0d rsp_data=0x%02h",
                 tag, a, w, hs_address, bus.rsp_valid, bus.rsp_data);
    endtask

    initial begin
        bus.req_valid = 1'b1; bus.req_address = 7'h10; bus.req_data = 8'h00; bus.req_is_write = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        samp();
        chk("rst_ack", 32'(bus.req_ack), 0);
        chk("rst_rspv", 32'(bus.rsp_valid), 0);
        chk("rst_acc", 32'(hs_access), 0);
        chk("rst_we", 32'(hs_write_enable), 0);
        chk("rst_addr", 32'(hs_address), 0);
        chk("rst_wdata", 32'(hs_data_in), 0);
        chk("rst_rdata", 32'(bus.rsp_data), 0);
        chk("rst_oor", 32'(oor_count), 0);
        step();
        reset_n = 1'b1;
        bus.req_valid = 1'b0;
        samp();
        chk("idle_noack", 32'(bus.req_ack), 0);

        // Writes and reads in both windows, including the window-2 edges
        run_req("wr05", 7'h05, 8'hA5, 1'b1, 12'h625, 8'h00);
        chk("ram625", 32'(ram[12'h625]), 32'h0A5);
        run_req("rd51", 7'h51, 8'h00, 1'b0, 12'h57F, 8'h3C);
        run_req("wr52", 7'h52, 8'h5A, 1'b1, 12'h580, 8'h00);
        run_req("rd52", 7'h52, 8'h00, 1'b0, 12'h580, 8'h5A);

        // CPU holds the port for four cycles; busy rising after acceptance is ignored
        step();
        bus.req_valid = 1'b1; bus.req_address = 7'h10; bus.req_is_write = 1'b0;
        cpu_ram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            samp();
            chk("busy_noack", 32'(bus.req_ack), 0);
            chk("busy_noacc", 32'(hs_access), 0);
        end
        step();
        cpu_ram_busy = 1'b0;
        samp();
        chk("busy_ack", 32'(bus.req_ack), 1);
        step();
        bus.req_valid = 1'b0;
        cpu_ram_busy = 1'b1;
        samp();
        chk("busy_acc_N1", 32'(hs_access), 1);
        chk("busy_addr_N1", 32'(hs_address), 32'h630);
        step();
        samp();
        chk("busy_acc_N2", 32'(hs_access), 1);
        step();
        cpu_ram_busy = 1'b0;
        samp();
        chk("busy_rspv", 32'(bus.rsp_valid), 1);
        chk("busy_rdata", 32'(bus.rsp_data), 32'h77);
        $display("req busy10 addr=0x10 rsp_data=0x%02h", bus.rsp_data);

        // Back-to-back reads at the first and last window-1 bytes
        step();
        bus.req_valid = 1'b1; bus.req_address = 7'h00; bus.req_is_write = 1'b0;
        samp();
        chk("b2b_ack0", 32'(bus.req_ack), 1);
        step();
        bus.req_address = 7'h4F;
        samp();
        chk("b2b_noack_setup", 32'(bus.req_ack), 0);
        chk("b2b_addr0", 32'(hs_address), 32'h620);
        step();
        samp();
        chk("b2b_noack_access", 32'(bus.req_ack), 0);
        step();
        samp();
        chk("b2b_rspv0", 32'(bus.rsp_valid), 1);
        chk("b2b_rdata0", 32'(bus.rsp_data), 32'h11);
        chk("b2b_ack1", 32'(bus.req_ack), 1);
        step();
        bus.req_valid = 1'b0;
        samp();
        chk("b2b_addr1", 32'(hs_address), 32'h66F);
        chk("b2b_rspv_gap", 32'(bus.rsp_valid), 0);
        step();
        samp();
        step();
        samp();
        chk("b2b_rspv1", 32'(bus.rsp_valid), 1);
        chk("b2b_rdata1", 32'(bus.rsp_data), 32'h22);
        $display("req b2b 0x00/0x4F rsp_data=0x%02h", bus.rsp_data);

        // Out-of-range read, then out-of-range write while the CPU is busy
        step();
        bus.req_valid = 1'b1; bus.req_address = 7'h60; bus.req_is_write = 1'b0;
        samp();
        chk("oor_ack", 32'(bus.req_ack), 1);
        chk("oor_noacc", 32'(hs_access), 0);
        step();
        bus.req_valid = 1'b0;
        samp();
        chk("oor_rspv", 32'(bus.rsp_valid), 1);
        chk("oor_rdata", 32'(bus.rsp_data), 32'hFF);
        chk("oor_cnt1", 32'(oor_count), 1);
        chk("oor_noacc2", 32'(hs_access), 0);
        step();
        bus.req_valid = 1'b1; bus.req_address = 7'h53; bus.req_data = 8'h99; bus.req_is_write = 1'b1;
        cpu_ram_busy = 1'b1;
        samp();
        chk("oorw_ack_busy", 32'(bus.req_ack), 1);
        step();
        bus.req_valid = 1'b0;
        cpu_ram_busy = 1'b0;
        samp();
        chk("oorw_cnt2", 32'(oor_count), 2);
        chk("oorw_norspv", 32'(bus.rsp_valid), 0);
        chk("oorw_noacc", 32'(hs_access), 0);
        chk("oorw_addr_hold", 32'(hs_address), 32'h66F);
        $display("req oor 0x60/0x53 oor_count=%0d", oor_count);

        for (int i = 0; i < 300; i++) begin
            step();
            bus.req_valid = 1'b1; bus.req_address = 7'h7F; bus.req_is_write = 1'b0;
            samp();
            step();
            bus.req_valid = 1'b0;
            samp();
        end
        step();
        samp();
        chk("oor_sat", 32'(oor_count), 255);
        chk("oor_sat_rdata", 32'(bus.rsp_data), 32'hFF);
        chk("idle_noack2", 32'(bus.req_ack), 0);
        $display("req oor x300 oor_count=%0d", oor_count);

        // Reset during the ACCESS cycle of a read
        step();
        bus.req_valid = 1'b1; bus.req_address = 7'h51; bus.req_is_write = 1'b0;
        samp();
        chk("rstmid_ack", 32'(bus.req_ack), 1);
        step();
        bus.req_valid = 1'b0;
        samp();
        step();
        reset_n = 1'b0;
        samp();
        chk("rstmid_acc_pre", 32'(hs_access), 1);
        step();
        reset_n = 1'b1;
        samp();
        chk("rstmid_acc", 32'(hs_access), 0);
        chk("rstmid_norspv", 32'(bus.rsp_valid), 0);
        chk("rstmid_oor", 32'(oor_count), 0);
        chk("rstmid_addr", 32'(hs_address), 0);
        step();
        samp();
        chk("rstmid_norspv2", 32'(bus.rsp_valid), 0);
        $display("req reset-in-access rsp_valid=%0d", bus.rsp_valid);
        run_req("rd51b", 7'h51, 8'h00, 1'b0, 12'h57F, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hs_ram_responder.md
HS_RAM_RESPONDER -- requirements
Module: hs_ram_responder

Interface
REQ-001 Parameter HS1_MAP, default 12'h620: core RAM base for request addresses 0x00-0x4F.
REQ-002 Parameter HS1_LEN, default 7'h50: length of window 1.
REQ-003 Parameter HS2_MAP, default 12'h57E: core RAM base for request addresses 0x50-0x52.
REQ-004 Parameter HS2_LEN, default 7'h03: length of window 2.
REQ-005 Parameter READ_LATENCY, default 1: cycles from address valid to hs_data_out valid; legal range 1-3.
REQ-006 Port jb_core_clk, in, 1: sole clock.
REQ-007 Port reset_n, in, 1: synchronous, active-low reset.
REQ-008 Port req_valid, in, 1: request present at the head of the CDC FIFO.
REQ-009 Port req_address, in, 7: byte offset into the 0x53-byte save image.
REQ-010 Port req_data, in, 8: write data.
REQ-011 Port req_is_write, in, 1: 1 means write, 0 means read.
REQ-012 Port req_ack, out, 1: one-cycle pop strobe to the FIFO.
REQ-013 Port rsp_valid, out, 1: one-cycle read-data strobe toward the clk_74a return buffer.
REQ-014 Port rsp_data, out, 8: read data, held until the next rsp_valid.
REQ-015 Port cpu_ram_busy, in, 1: core CPU is using the shared RAM port.
REQ-016 Port hs_address, out, 12: core RAM address.
REQ-017 Port hs_access, out, 1: RAM port mux select; 1 means this block owns the port.
REQ-018 Port hs_write_enable, out, 1: RAM write strobe.
REQ-019 Port hs_data_in, out, 8: RAM write data.
REQ-020 Port hs_data_out, in, 8: RAM read data.
REQ-021 Port oor_count, out, 8: saturating count of out-of-range requests.

Function
REQ-022 Address mapping: addr < HS1_LEN maps to HS1_MAP+addr; HS1_LEN <= addr < HS1_LEN+HS2_LEN maps to HS2_MAP+(addr-HS1_LEN); computed in 12 bits, no wrap.
REQ-023 States: IDLE, SETUP, ACCESS, OOR.
REQ-024 IDLE transitions:
  - on req_valid && !cpu_ram_busy && in range: pulse req_ack in that cycle, latch the request, go to SETUP;
  - on req_valid && out of range: pulse req_ack regardless of cpu_ram_busy, go to OOR;
  - otherwise remain in IDLE.
REQ-025 In IDLE, req_ack is never asserted without req_valid, and hs_access=0.
REQ-026 SETUP: hs_access=1, hs_address=mapped address, hs_write_enable=0; go to ACCESS after one cycle.
REQ-027 ACCESS, write: hs_write_enable=1 and hs_data_in=latched data for exactly one cycle, then IDLE, with no rsp_valid.
REQ-028 ACCESS, read: stay READ_LATENCY cycles with hs_access=1, capture hs_data_out on the final cycle, then IDLE with rsp_valid=1 for one cycle.
REQ-029 At READ_LATENCY=1, a request accepted at cycle N has hs_access high in N+1..N+2, and rsp_valid (for reads) at N+3.
REQ-030 At N+3 the block accepts a new request, so sustained throughput is one request per 3 cycles.
REQ-031 cpu_ram_busy is sampled only in IDLE; once SETUP is entered, the block holds the port until ACCESS completes.
REQ-032 OOR: no RAM access; a read returns rsp_data=8'hFF with rsp_valid one cycle later; a write is dropped; oor_count increments and saturates at 255; return to IDLE.
REQ-033 hs_address and hs_data_in hold their last values when hs_access=0; hs_write_enable is 0 outside ACCESS.
REQ-034 Simultaneous req_valid and cpu_ram_busy with an in-range address: no ack, wait in IDLE, request stays in the FIFO.

Reset
REQ-035 While reset_n=0 at a clock edge: state to IDLE, and req_ack, rsp_valid, hs_access, hs_write_enable to 0.
REQ-036 Reset also clears hs_address, hs_data_in, rsp_data and oor_count to 0.
REQ-037 Reset mid-operation abandons the latched request: no rsp_valid, no write strobe after the reset edge.
REQ-038 hs_access deasserts at the first reset edge.

Structure
REQ-039 Shared package jailbreak_hs_pkg holds:
  - mem_access_t (address 7, data 8, is_write 1), shared with the clk_74a side;
  - HS window constants;
  - state_t.
REQ-040 Address mapping is one combinational sub-module, hs_addr_remap, with outputs mapped address and in_range.

Verification
REQ-041 Write addr 0x05 data 0xA5, cpu_ram_busy=0 -> req_ack at N, hs_address=0x625, hs_write_enable at N+2 only, no rsp_valid.
REQ-042 Read addr 0x51, RAM[0x57F]=0x3C -> hs_address=0x57F at N+1, rsp_valid with rsp_data=0x3C at N+3.
REQ-043 req_valid read addr 0x10 with cpu_ram_busy high for 4 cycles -> no ack or hs_access until busy falls; ack in first cycle busy=0.
REQ-044 Read addr 0x60 -> immediate ack, no hs_access, rsp_data=0xFF, oor_count=1; 300 such requests -> oor_count=255.
REQ-045 Reset asserted during ACCESS of a read -> no rsp_valid, hs_access=0 next cycle, next request serviced normally.
REQ-046 Back-to-back reads 0x00 and 0x4F -> hs_address 0x620 then 0x66F, rsp_valid spaced 3 cycles apart.
